// File: rtl/piso8_tx_if.sv
// ============================================================================
// Module      : piso8_tx_if
// Description : Load handshake and serial-output bundle for piso8_tx.
//               master = word source / serial sink, slave = transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso8_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] D;
   logic             load_valid;
   logic             load_ready;
   logic             abort;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   modport master (
      output D, load_valid, abort,
      input  load_ready, sout, sout_valid, busy, done
   );

   modport slave (
      input  D, load_valid, abort,
      output load_ready, sout, sout_valid, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/piso8_tx.sv
// ============================================================================
// Module      : piso8_tx
// Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word
//               on a valid/ready handshake, shifts it out one bit per clock
//               and pulses done for one cycle after the last bit.
//               Optional macro PISO8_TX_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso8_tx #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  wire logic      clk,
   input  wire logic      reset,
   piso8_tx_if.slave      bus
);

   localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO8_TX_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_DONE   = 2'd2,
      S_PARITY = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             head;
`ifdef PISO8_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // The head bit sits at the end of the register the shift moves toward.
   generate
      if (LSB_FIRST) begin : g_lsb_head
         assign head = shreg_q[0];
      end else begin : g_msb_head
         assign head = shreg_q[WIDTH-1];
      end
   endgenerate

   // Next-state logic: capture, shift/count, abort and terminal transitions.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
`ifdef PISO8_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            // abort is deliberately ignored here so a concurrent load wins
            if (bus.load_valid) begin
               shreg_d  = bus.D;
               cnt_d    = '0;
               state_d  = S_SHIFT;
`ifdef PISO8_TX_PARITY_EN
               parity_d = ^bus.D;
`endif
            end
         end
         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
`ifdef PISO8_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
`ifdef PISO8_TX_PARITY_EN
         S_PARITY: begin
            state_d = bus.abort ? S_IDLE : S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset discards any partial word immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
`ifdef PISO8_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
`ifdef PISO8_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs are decoded from registered state only; D never reaches sout
   // without passing through the shift register.
   assign bus.load_ready = (state_q == S_IDLE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
`ifdef PISO8_TX_PARITY_EN
   assign bus.sout_valid = (state_q == S_SHIFT) || (state_q == S_PARITY);
   assign bus.sout       = (state_q == S_SHIFT)  ? head     :
                           (state_q == S_PARITY) ? parity_q : 1'b0;
`else
   assign bus.sout_valid = (state_q == S_SHIFT);
   assign bus.sout       = (state_q == S_SHIFT) ? head : 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/piso8_tx.md
Name: piso8_tx

Overview:
- Parallel-in/serial-out transmitter: the read side of an 8-bit parallel register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a serial line.
- Asserts a one-cycle done pulse when the word has been sent.
- Sits between a register-bank output and a 1-bit serial link or bus.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- LSB_FIRST, 1, 1 = shift D[0] first; 0 = shift D[WIDTH-1] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- D  input  WIDTH  parallel data word to transmit.
- load_valid  input  1  D is valid; request to transmit.
- load_ready  output  1  block can accept a word this cycle.
- abort  input  1  synchronous cancel of the word in flight.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- busy  output  1  a transfer is in progress (not IDLE).
- done  output  1  one-cycle pulse after the last bit is sent.

Behaviour:
- Reset:
  - reset low asynchronously forces state IDLE and clears the shift register and bit counter.
  - Outputs during and after reset: sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT, (PARITY when PARITY_EN is defined), DONE. All outputs are registered or decoded from state; no combinational path from D to sout.
- IDLE:
  - load_ready=1.
  - On load_valid=1 at a rising edge: capture D into the shift register, clear the counter, go to SHIFT.
  - load_valid=0: stay in IDLE.
- SHIFT:
  - sout_valid=1, busy=1, load_ready=0.
  - sout = current head bit. Head bit is D[0] first when LSB_FIRST=1, otherwise D[WIDTH-1] first.
  - Each edge: shift by one and increment the counter.
  - On the edge where counter==WIDTH-1: go to DONE (or PARITY when enabled).
- DONE:
  - sout_valid=0, sout=0, done=1 for exactly one cycle.
  - Next edge: IDLE.
- Timing, with the load accepted at edge N:
  - bit k is on sout in cycle N+1+k, for k=0..WIDTH-1.
  - done is high in cycle N+WIDTH+1.
  - load_ready returns high in cycle N+WIDTH+2.
  - Throughput is one word per WIDTH+2 cycles.
- load_valid asserted while load_ready=0 is ignored. The captured word is unaffected by later changes on D.
- abort:
  - abort=1 in SHIFT or PARITY: next edge goes to IDLE, done is not pulsed, sout_valid drops.
  - abort in IDLE or DONE has no effect.
  - abort and load_valid both high in IDLE: the load is accepted; abort is ignored.
- Reset mid-transfer aborts immediately: no done pulse, and the partial word is discarded.

Optional Feature:
- Macro: PISO8_TX_PARITY_EN.
- Defined:
  - After the last data bit, the block enters PARITY for one cycle.
  - In PARITY, sout = XOR of all WIDTH captured bits (even parity) and sout_valid=1.
  - done moves to cycle N+WIDTH+2; throughput is one word per WIDTH+3 cycles.
- Undefined: the PARITY state and its logic are absent; timing is as given under Behaviour.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, then release -> sout=0, sout_valid=0, busy=0, done=0, load_ready=1 throughout.
- LSB-first send (WIDTH=8, LSB_FIRST=1): D=8'hA5 with load_valid for 1 cycle -> sout 1,0,1,0,0,1,0,1 over 8 cycles with sout_valid=1, done in cycle 9, load_ready back in cycle 10.
- MSB-first send (LSB_FIRST=0): D=8'h81 -> sout 1,0,0,0,0,0,0,1, then the done pulse.
- Busy guard: accept 8'h0F, then present 8'hFF with load_valid during SHIFT -> sequence is still 1,1,1,1,0,0,0,0; the second word is not taken until load_ready=1.
- Abort and reset mid-word:
  - abort in SHIFT cycle 3 -> IDLE next cycle, no done pulse, load_ready=1.
  - Repeat with reset low in cycle 3 -> outputs clear immediately, without waiting for a clock edge.
- Parity (PISO8_TX_PARITY_EN defined): D=8'h07 -> 8 data bits, then sout=1 with sout_valid=1, done in cycle 10. D=8'h03 -> parity bit 0.
